// File: rtl/kfpga_config_pkg.sv
// Shared definitions for the kFPGA configuration loader.
// Provides the loader state encoding and the chain geometry of this core variant.
package kfpga_config_pkg;

  // Chain geometry of the default kFPGA core variant.
  localparam int unsigned DefaultConfigLength = 34688;
  localparam int unsigned DefaultWordWidth    = 8;
  localparam int unsigned DefaultClearCycles  = 2;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StShift,
    StDone
  } loader_state_e;

endpackage

// File: rtl/kfpga_config_loader_if.sv
// Word stream carrying the configuration bitstream into the loader.
//   word_data  : bitstream word, MSB shifted first
//   word_valid : word_data is valid (driven by the source)
//   word_ready : loader accepts the word this cycle (driven by the loader)
// modport master : word source (host, SPI slave, ROM reader)
// modport slave  : the loader
interface kfpga_config_loader_if
  import kfpga_config_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = DefaultWordWidth
) ();

  logic [WORD_WIDTH-1:0] word_data;
  logic                  word_valid;
  logic                  word_ready;

  modport master (
    output word_data,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  word_data,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/kfpga_config_loader.sv
// Serialises a word-wide configuration bitstream onto the kFPGA core's config chain.
// A load clears the chain, shifts exactly CONFIG_LENGTH bits (MSB of each word first),
// then stops with done held high until the next start.
// Ports:
//   clock           : single clock, also the chain's config_clock
//   nreset          : asynchronous active-low reset
//   start_i         : one-cycle load request, honoured only when idle or done
//   abort_i         : return to idle from any state (beats start and the handshake)
//   bus             : word stream (slave side); word_ready is high only while loading
//   config_data_o   : chain config_in
//   config_enable_o : chain config_enable, high only while shifting
//   config_nreset_o : chain config_nreset, low during the clear phase
//   busy_o          : high while clearing, loading or shifting
//   done_o          : chain fully loaded (level)
module kfpga_config_loader
  import kfpga_config_pkg::*;
#(
  parameter int unsigned WORD_WIDTH    = DefaultWordWidth,
  parameter int unsigned CONFIG_LENGTH = DefaultConfigLength,
  parameter int unsigned CLEAR_CYCLES  = DefaultClearCycles  // must be >= 1
) (
  input  logic                        clock,
  input  logic                        nreset,
  input  logic                        start_i,
  input  logic                        abort_i,
  kfpga_config_loader_if.slave        bus,
  output logic                        config_data_o,
  output logic                        config_enable_o,
  output logic                        config_nreset_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned BIT_CNT_W = $clog2(CONFIG_LENGTH + 1);
  localparam int unsigned LAST_BITS = CONFIG_LENGTH % WORD_WIDTH;
  // Width of the final word; a zero remainder means the last word is full.
  localparam int unsigned FinalBits = (LAST_BITS == 0) ? WORD_WIDTH : LAST_BITS;
  localparam int unsigned WordCntW  = $clog2(WORD_WIDTH + 1);
  localparam int unsigned ClrCntW   = $clog2(CLEAR_CYCLES + 1);

  loader_state_e          state_q;
  logic [WORD_WIDTH-1:0]  shreg_q;
  logic [WordCntW-1:0]    word_bits_q;
  logic [BIT_CNT_W-1:0]   bits_left_q;
  logic [ClrCntW-1:0]     clr_cnt_q;
  logic                   config_data_q;
  logic                   config_enable_q;
  logic                   config_nreset_q;
  logic                   busy_q;
  logic                   done_q;

  logic [WordCntW-1:0]    word_bits_d;

  // Bits left are always word-aligned at a capture, so anything at or below one word
  // is the final (possibly partial) word.
  always_comb begin
    word_bits_d = WordCntW'(WORD_WIDTH);
    if (32'(bits_left_q) <= WORD_WIDTH) begin
      word_bits_d = WordCntW'(FinalBits);
    end
  end

  // shreg_q holds the bits that follow the one currently on config_data_q, so the
  // serial output is a register and changes together with config_enable_q.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q         <= StIdle;
      shreg_q         <= '0;
      word_bits_q     <= '0;
      bits_left_q     <= '0;
      clr_cnt_q       <= '0;
      config_data_q   <= 1'b0;
      config_enable_q <= 1'b0;
      config_nreset_q <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else if (abort_i) begin
      state_q         <= StIdle;
      shreg_q         <= '0;
      word_bits_q     <= '0;
      bits_left_q     <= '0;
      clr_cnt_q       <= '0;
      config_data_q   <= 1'b0;
      config_enable_q <= 1'b0;
      config_nreset_q <= 1'b1;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            state_q         <= StClear;
            config_nreset_q <= 1'b0;
            clr_cnt_q       <= ClrCntW'(CLEAR_CYCLES - 1);
            bits_left_q     <= BIT_CNT_W'(CONFIG_LENGTH);
            busy_q          <= 1'b1;
            done_q          <= 1'b0;
          end
        end
        StClear: begin
          if (clr_cnt_q == '0) begin
            state_q         <= StLoad;
            config_nreset_q <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q - 1'b1;
          end
        end
        StLoad: begin
          if (bus.word_valid) begin
            state_q         <= StShift;
            config_enable_q <= 1'b1;
            config_data_q   <= bus.word_data[WORD_WIDTH-1];
            shreg_q         <= bus.word_data << 1;
            word_bits_q     <= word_bits_d;
          end
        end
        StShift: begin
          bits_left_q <= bits_left_q - 1'b1;
          word_bits_q <= word_bits_q - 1'b1;
          if (word_bits_q == WordCntW'(1)) begin
            // Remaining low bits of a partial final word are simply dropped.
            config_enable_q <= 1'b0;
            config_data_q   <= 1'b0;
            if (bits_left_q == BIT_CNT_W'(1)) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StLoad;
            end
          end else begin
            config_data_q <= shreg_q[WORD_WIDTH-1];
            shreg_q       <= shreg_q << 1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.word_ready   = (state_q == StLoad);
  assign config_data_o    = config_data_q;
  assign config_enable_o  = config_enable_q;
  assign config_nreset_o  = config_nreset_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_kfpga_config_loader.sv
module tb_kfpga_config_loader;

  localparam int unsigned L  = 20;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = 3;   // ceil(L / W)
  localparam int unsigned CC = 2;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  logic start_i = 1'b0;
  logic abort_i = 1'b0;
  logic config_data_o, config_enable_o, config_nreset_o, busy_o, done_o;

  kfpga_config_loader_if #(.WORD_WIDTH(W)) bus ();

  kfpga_config_loader #(
    .WORD_WIDTH   (W),
    .CONFIG_LENGTH(L),
    .CLEAR_CYCLES (CC)
  ) dut (
    .clock          (clock),
    .nreset         (nreset),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .bus            (bus),
    .config_data_o  (config_data_o),
    .config_enable_o(config_enable_o),
    .config_nreset_o(config_nreset_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clock = ~clock;

  // Chain model and event counters.
  int cyc = 0, hs_cnt = 0, en_cnt = 0, clr_cnt = 0, viol = 0;
  logic [L-1:0] chain = '0;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (bus.word_valid && bus.word_ready) hs_cnt <= hs_cnt + 1;
    if (config_enable_o) en_cnt <= en_cnt + 1;
    if (!config_nreset_o) clr_cnt <= clr_cnt + 1;
    if (bus.word_ready && config_enable_o) viol <= viol + 1;
    if (!config_nreset_o) chain <= '0;
    else if (config_enable_o) chain <= {chain[L-2:0], config_data_o};
  end

  int n_tests = 0, n_fail = 0;
  logic [W-1:0] wq [NW];
  int gq [NW];
  int start_cyc, hs0, en0, clr0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stream bit k is word k/W, bit W-1-(k%W); first bit lands at chain bit L-1.
  function automatic logic [L-1:0] expected_image();
    logic [L-1:0] img;
    for (int k = 0; k < int'(L); k++) img[int'(L) - 1 - k] = wq[k / int'(W)][int'(W) - 1 - (k % int'(W))];
    return img;
  endfunction

  task automatic randomize_words(input int max_gap);
    for (int i = 0; i < int'(NW); i++) begin
      wq[i] = W'($urandom);
      gq[i] = $urandom_range(0, max_gap);
    end
  endtask

  task automatic begin_load();
    @(negedge clock);
    start_i = 1'b1;
    start_cyc = cyc;
    hs0 = hs_cnt;
    en0 = en_cnt;
    clr0 = clr_cnt;
    @(negedge clock);
    start_i = 1'b0;
    check("clear_nreset_low", config_nreset_o, 1'b0);
    check("clear_busy", busy_o, 1'b1);
  endtask

  task automatic feed(input int i, input bit poke);
    int t = 0;
    while (!bus.word_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("word_ready_wait", bus.word_ready, 1'b1);
    if (i == 0) check("chain_cleared", chain, '0);
    repeat (gq[i]) @(negedge clock);
    bus.word_valid = 1'b1;
    bus.word_data  = wq[i];
    @(negedge clock);
    bus.word_valid = 1'b0;
    bus.word_data  = W'($urandom);
    if (poke) begin
      start_i = 1'b1;
      @(negedge clock);
      start_i = 1'b0;
    end
  endtask

  task automatic finish_load();
    int t = 0;
    int gaps = 0;
    while (!done_o && t < 300) begin
      @(negedge clock);
      t++;
    end
    for (int i = 0; i < int'(NW); i++) gaps += gq[i];
    check("done", done_o, 1'b1);
    check("done_busy", busy_o, 1'b0);
    check("done_enable", config_enable_o, 1'b0);
    check("done_data", config_data_o, 1'b0);
    check("done_ready", bus.word_ready, 1'b0);
    check("enable_cycles", en_cnt - en0, L);
    check("handshakes", hs_cnt - hs0, NW);
    check("clear_cycles", clr_cnt - clr0, CC);
    check("enable_in_load", viol, 0);
    check("latency", cyc - start_cyc, 1 + CC + NW + L + gaps);
    check("chain_image", chain, expected_image());
  endtask

  task automatic full_load(input bit poke);
    begin_load();
    for (int i = 0; i < int'(NW); i++) feed(i, poke && (i == 0));
    finish_load();
  endtask

  initial begin
    int t;
    bus.word_valid = 1'b0;
    bus.word_data  = '0;

    // Reset held with start asserted.
    start_i = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_ready", bus.word_ready, 1'b0);
    check("rst_data", config_data_o, 1'b0);
    check("rst_enable", config_enable_o, 1'b0);
    check("rst_nreset", config_nreset_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    start_i = 1'b0;
    nreset  = 1'b1;
    repeat (2) @(negedge clock);
    check("idle_busy", busy_o, 1'b0);

    // Directed small image.
    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'hF0;
    gq[0] = 0; gq[1] = 0; gq[2] = 0;
    full_load(1'b0);
    check("directed_image", chain, 20'hA53CF);

    // Backpressure: 5 cycles without valid while in LOAD.
    gq[1] = 5;
    full_load(1'b0);
    check("bp_image", chain, 20'hA53CF);

    // start during SHIFT is ignored; valid in DONE is not accepted.
    randomize_words(2);
    full_load(1'b1);
    bus.word_valid = 1'b1;
    bus.word_data  = W'($urandom);
    repeat (4) @(negedge clock);
    bus.word_valid = 1'b0;
    check("done_no_hs", hs_cnt - hs0, NW);
    check("done_hold", done_o, 1'b1);
    check("done_no_enable", en_cnt - en0, L);

    // Abort after 11 bits, with a simultaneous start that must lose.
    randomize_words(0);
    begin_load();
    feed(0, 1'b0);
    feed(1, 1'b0);
    t = 0;
    while ((en_cnt - en0) < 11 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("abort_point", en_cnt - en0, 11);
    abort_i = 1'b1;
    start_i = 1'b1;
    @(negedge clock);
    abort_i = 1'b0;
    start_i = 1'b0;
    check("abort_enable", config_enable_o, 1'b0);
    check("abort_done", done_o, 1'b0);
    check("abort_busy", busy_o, 1'b0);
    check("abort_ready", bus.word_ready, 1'b0);
    check("abort_nreset", config_nreset_o, 1'b1);
    repeat (2) @(negedge clock);
    check("abort_stay_idle", busy_o, 1'b0);
    randomize_words(3);
    full_load(1'b0);

    // Reset in the middle of a load.
    randomize_words(0);
    begin_load();
    feed(0, 1'b0);
    @(negedge clock);
    nreset = 1'b0;
    #1;
    check("midrst_enable", config_enable_o, 1'b0);
    check("midrst_data", config_data_o, 1'b0);
    check("midrst_busy", busy_o, 1'b0);
    check("midrst_nreset", config_nreset_o, 1'b1);
    check("midrst_ready", bus.word_ready, 1'b0);
    @(negedge clock);
    nreset = 1'b1;
    randomize_words(3);
    full_load(1'b0);

    // Randomized images with random LOAD stalls.
    for (int r = 0; r < 4; r++) begin
      randomize_words(3);
      full_load(1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kfpga_config_loader.md
Name: kfpga_config_loader

Overview:
- Upstream feeder for the core top's configuration shift register: accepts the bitstream as parallel words over a valid/ready stream and serialises it onto the chain's config_in/config_enable/config_nreset inputs.
- Clears the chain, shifts exactly CONFIG_LENGTH bits, then stops and reports done.
- Lets a host, SPI slave or ROM reader program the fabric without knowing the chain length.

Parameters:
- WORD_WIDTH, 8, bits per input word.
- CONFIG_LENGTH, 34688, total chain length in bits.
- CLEAR_CYCLES, 2, cycles config_nreset is held low before shifting; must be ≥1.
- Derived localparams (not overridable): BIT_CNT_W = $clog2(CONFIG_LENGTH+1); LAST_BITS = CONFIG_LENGTH % WORD_WIDTH, where 0 means full words.

Ports:
- clock  in  1  single clock; the chain's config_clock is driven from the same net.
- nreset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; ignored unless in IDLE or DONE.
- abort  in  1  return to IDLE from any state.
- word_data  in  WORD_WIDTH  bitstream word; bit WORD_WIDTH-1 is shifted first.
- word_valid  in  1  word_data valid.
- word_ready  out  1  loader accepts word this cycle.
- config_data  out  1  drives chain config_in.
- config_enable  out  1  drives chain config_enable.
- config_nreset  out  1  drives chain config_nreset, active-low.
- busy  out  1  high in CLEAR, LOAD, SHIFT.
- done  out  1  level; chain fully loaded.

Behaviour:
- Reset values (async, immediate on nreset low): state=IDLE, word_ready=0, config_data=0, config_enable=0, config_nreset=1, busy=0, done=0, counters=0.
- All outputs are registered except word_ready. word_ready = (state==LOAD).
- States:
  - IDLE: start → CLEAR.
  - CLEAR: config_nreset=0 for CLEAR_CYCLES cycles; bits_left loaded with CONFIG_LENGTH; then → LOAD.
  - LOAD: word_ready=1. On word_valid&word_ready, word_data is captured into shreg, word_bits=min(WORD_WIDTH, bits_left); → SHIFT.
  - SHIFT: each cycle config_enable=1, config_data=shreg[WORD_WIDTH-1]; shreg shifts left by 1; word_bits and bits_left decrement. When word_bits reaches 1 in this cycle: if bits_left==1 → DONE, else → LOAD.
  - DONE: done=1, config_enable=0. start → CLEAR, clearing done. Words presented in DONE are not accepted (word_ready=0).
- config_enable and config_data change together, so the chain samples each bit on the next rising clock edge.
- Bit mapping: first bit shifted (word 0, bit WORD_WIDTH-1) lands at chain bit CONFIG_LENGTH-1. The last bit shifted lands at chain bit 0.
- Throughput: WORD_WIDTH+1 cycles per full word (1 LOAD + WORD_WIDTH SHIFT), with no stall beyond word_valid latency.
- Final word when LAST_BITS≠0: only its upper LAST_BITS bits are shifted; the lower bits are discarded.
- Total words consumed = ceil(CONFIG_LENGTH/WORD_WIDTH). Exactly CONFIG_LENGTH cycles of config_enable=1 occur per load.
- config_enable=0 in all states except SHIFT; config_data=0 outside SHIFT.
- word_valid low in LOAD: the loader waits indefinitely and the chain holds.
- abort in any state → IDLE next cycle: config_enable=0, done=0, chain contents undefined. abort has priority over start and over the handshake in the same cycle.
- start while busy: ignored.
- Reset mid-load: loader returns to reset values; the chain is not cleared by the loader reset itself; the next start clears it.

Decomposition:
- Shared package kfpga_config_pkg: state enum (IDLE, CLEAR, LOAD, SHIFT, DONE) and default CONFIG_LENGTH/WORD_WIDTH constants for this core variant.
- No sub-module; FSM, word shifter and counters sit in one module.
- Integration wrapper, not part of this block: the loader outputs wire directly to kFPGACoreTop config ports.

Test Plan:
- Reset: nreset low with start=1 → all outputs at reset values; busy=0, config_nreset=1.
- Small config (CONFIG_LENGTH=20, WORD_WIDTH=8): start, words 0xA5, 0x3C, 0xF0 → config_nreset low for 2 cycles; exactly 20 enable cycles; serial stream 10100101 00111100 1111; done=1; 3 handshakes.
- Backpressure: word_valid held low 5 cycles in LOAD → config_enable stays 0, no bits lost; resumed stream matches the previous case bit-for-bit.
- Full-length integration (default params, chain attached): random 4336-byte image → the chain's 34688-bit register equals the image MSB-first; config_out equals the first bit shifted.
- Abort after 11 bits → IDLE next cycle, done=0, config_enable=0. A new start then clears the chain and a full reload produces the correct image.
- start pulsed during SHIFT and word_valid asserted in DONE → both ignored; no extra handshakes; bit count stays 20.
